// File: rtl/imm_gen_stage_if.sv
// imm_gen_stage_if
// Handshake bundle between the IF/ID side, the immediate-generation stage and
// the ID/EX side.
//   in_valid/in_ready   : upstream offer / stage accept
//   instr_in[31:7]      : instruction bits carrying the immediate fields
//   imm_sel_in[2:0]     : immediate format select
//   pc_in[XLEN-1:0]     : PC of the offered instruction
//   flush               : synchronous kill of every held entry
//   out_valid/out_ready : stage offer / downstream accept
//   imm_out, target_out : extended immediate and pc + imm
//   illegal_imm         : entry carried a reserved or out-of-range select
// The slave modport is the stage's view; master is the surrounding pipeline.
interface imm_gen_stage_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [31:7]     instr_in;
  logic [2:0]      imm_sel_in;
  logic [XLEN-1:0] pc_in;
  logic            flush;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] imm_out;
  logic [XLEN-1:0] target_out;
  logic            illegal_imm;

  modport master (
    output in_valid, instr_in, imm_sel_in, pc_in, flush, out_ready,
    input  in_ready, out_valid, imm_out, target_out, illegal_imm
  );

  modport slave (
    input  in_valid, instr_in, imm_sel_in, pc_in, flush, out_ready,
    output in_ready, out_valid, imm_out, target_out, illegal_imm
  );
endinterface

// File: rtl/imm_gen_stage.sv
// imm_gen_stage
// Registered immediate generator for the decode pipeline. The immediate and
// the PC-relative target are formed combinationally from the offered
// instruction and captured on acceptance, so no output depends
// combinationally on the instruction, select or PC inputs.
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : imm_gen_stage_if.slave (input handshake, output handshake, flush)
// Parameters:
//   XLEN  : 32 or 64
//   SKID  : 1 = registered in_ready with one skid entry,
//           0 = combinational in_ready with a single output register
module imm_gen_stage #(
  parameter int XLEN = 32,
  parameter bit SKID = 1'b1
) (
  input logic            clk,
  input logic            rst_n,
  imm_gen_stage_if.slave bus
);

  typedef struct packed {
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] target;
    logic            illegal;
  } entry_t;

  localparam logic [2:0] SEL_I  = 3'b000;
  localparam logic [2:0] SEL_S  = 3'b001;
  localparam logic [2:0] SEL_B  = 3'b010;
  localparam logic [2:0] SEL_U  = 3'b011;
  localparam logic [2:0] SEL_J  = 3'b100;
  localparam logic [2:0] SEL_Z  = 3'b101;
  localparam logic [2:0] SEL_SH = 3'b110;

  logic [XLEN-1:0] imm_c;
  logic            illegal_c;
  entry_t          new_entry;

  entry_t main_q;
  entry_t skid_q;
  logic   main_valid;
  logic   skid_valid;
  logic   in_ready_q;

  logic   in_ready_int;
  logic   accept;
  logic   main_free;
  logic   main_valid_n;
  logic   skid_valid_n;
  logic   load_main_in;
  logic   load_main_skid;
  logic   load_skid;

  // Immediate extraction. Sign-extended formats start from a word filled
  // with instr[31] and then overwrite the low bits, which keeps the same
  // code valid for both XLEN values.
  always_comb begin
    imm_c     = '0;
    illegal_c = 1'b0;
    case (bus.imm_sel_in)
      SEL_I: begin
        imm_c       = {XLEN{bus.instr_in[31]}};
        imm_c[10:0] = bus.instr_in[30:20];
      end
      SEL_S: begin
        imm_c       = {XLEN{bus.instr_in[31]}};
        imm_c[10:0] = {bus.instr_in[30:25], bus.instr_in[11:7]};
      end
      SEL_B: begin
        imm_c       = {XLEN{bus.instr_in[31]}};
        imm_c[11:0] = {bus.instr_in[7], bus.instr_in[30:25],
                       bus.instr_in[11:8], 1'b0};
      end
      SEL_U: begin
        imm_c       = {XLEN{bus.instr_in[31]}};
        imm_c[31:0] = {bus.instr_in[31:12], 12'b0};
      end
      SEL_J: begin
        imm_c       = {XLEN{bus.instr_in[31]}};
        imm_c[19:0] = {bus.instr_in[19:12], bus.instr_in[20],
                       bus.instr_in[30:21], 1'b0};
      end
      SEL_Z: begin
        imm_c[4:0] = bus.instr_in[19:15];
      end
      SEL_SH: begin
        // RV32 only has 5-bit shift amounts; a set bit 25 is flagged but
        // the low five bits are still passed on.
        if (XLEN == 64) begin
          imm_c[5:0] = bus.instr_in[25:20];
        end else begin
          imm_c[4:0] = bus.instr_in[24:20];
          illegal_c  = bus.instr_in[25];
        end
      end
      default: begin
        illegal_c = 1'b1;
      end
    endcase
  end

  // Entry presented for capture; the add wraps naturally at XLEN bits.
  always_comb begin
    new_entry         = '0;
    new_entry.imm     = imm_c;
    new_entry.target  = bus.pc_in + imm_c;
    new_entry.illegal = illegal_c;
  end

  // Next-state control for the main and skid registers. Flush wins over
  // everything and also masks the acceptance of an input offered with it.
  // The skid entry is only ever loaded while main is stalled, so whenever
  // main frees up a waiting skid entry takes precedence over new input,
  // which is blocked anyway because in_ready is low while skid is full.
  always_comb begin
    in_ready_int   = SKID ? in_ready_q : (!main_valid || bus.out_ready);
    accept         = bus.in_valid && in_ready_int && !bus.flush;
    main_free      = !main_valid || bus.out_ready;
    main_valid_n   = main_valid;
    skid_valid_n   = skid_valid;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    if (bus.flush) begin
      main_valid_n = 1'b0;
      skid_valid_n = 1'b0;
    end else if (main_free) begin
      if (skid_valid) begin
        load_main_skid = 1'b1;
        main_valid_n   = 1'b1;
        skid_valid_n   = 1'b0;
      end else if (accept) begin
        load_main_in = 1'b1;
        main_valid_n = 1'b1;
      end else begin
        main_valid_n = 1'b0;
      end
    end else if (accept && SKID) begin
      load_skid    = 1'b1;
      skid_valid_n = 1'b1;
    end
  end

  // Storage. in_ready_q mirrors "skid empty next cycle" so that the
  // registered in_ready never needs a combinational path from out_ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_q     <= '0;
      skid_q     <= '0;
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      in_ready_q <= 1'b1;
    end else begin
      main_valid <= main_valid_n;
      skid_valid <= skid_valid_n;
      in_ready_q <= !skid_valid_n;
      if (load_main_in) begin
        main_q <= new_entry;
      end else if (load_main_skid) begin
        main_q <= skid_q;
      end
      if (load_skid) begin
        skid_q <= new_entry;
      end
    end
  end

  assign bus.in_ready    = in_ready_int;
  assign bus.out_valid   = main_valid;
  assign bus.imm_out     = main_q.imm;
  assign bus.target_out  = main_q.target;
  assign bus.illegal_imm = main_q.illegal;

endmodule

// File: tb/tb_imm_gen_stage.sv
// tb_imm_gen_stage
// Scoreboard bench for imm_gen_stage. Two instances run side by side:
// an XLEN=32 stage with the skid buffer and an XLEN=64 stage without it.
// Stimulus pushes hand-computed expected entries when an input is accepted;
// per-instance monitors pop and compare whenever an output is consumed.
module tb_imm_gen_stage;

  typedef struct {
    logic [63:0] imm;
    logic [63:0] target;
    logic        ill;
  } exp_t;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;
  exp_t q32[$];
  exp_t q64[$];
  exp_t e32;
  exp_t e64;

  imm_gen_stage_if #(.XLEN(32)) b32 ();
  imm_gen_stage_if #(.XLEN(64)) b64 ();

  imm_gen_stage #(.XLEN(32), .SKID(1'b1)) dut32 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b32.slave)
  );

  imm_gen_stage #(.XLEN(64), .SKID(1'b0)) dut64 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b64.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [63:0] act,
                              input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("[TB] FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Offer one instruction to the 32-bit stage and wait (bounded) for it to
  // be accepted; the expected entry is queued when acceptance is certain.
  task automatic send32(input logic [31:0] instr, input logic [2:0] sel,
                        input logic [31:0] pc, input logic [31:0] eimm,
                        input logic [31:0] etgt, input logic eill);
    bit done;
    done = 1'b0;
    b32.in_valid   = 1'b1;
    b32.instr_in   = instr[31:7];
    b32.imm_sel_in = sel;
    b32.pc_in      = pc;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      if (b32.in_ready) begin
        q32.push_back('{imm: {32'b0, eimm}, target: {32'b0, etgt}, ill: eill});
        done = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    if (!done) begin
      total++;
      bad++;
      $display("[TB] FAIL send32_timeout actual=no accept required=accept");
    end
  endtask

  task automatic send64(input logic [31:0] instr, input logic [2:0] sel,
                        input logic [63:0] pc, input logic [63:0] eimm,
                        input logic [63:0] etgt, input logic eill);
    bit done;
    done = 1'b0;
    b64.in_valid   = 1'b1;
    b64.instr_in   = instr[31:7];
    b64.imm_sel_in = sel;
    b64.pc_in      = pc;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      if (b64.in_ready) begin
        q64.push_back('{imm: eimm, target: etgt, ill: eill});
        done = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    if (!done) begin
      total++;
      bad++;
      $display("[TB] FAIL send64_timeout actual=no accept required=accept");
    end
  endtask

  task automatic apply_stimulus_idle(input int cycles);
    b32.in_valid = 1'b0;
    b64.in_valid = 1'b0;
    repeat (cycles) @(posedge clk);
    #1;
  endtask

  // Output monitors: every consumed entry must match the oldest expected one.
  always @(negedge clk) begin
    if (rst_n && b32.out_valid && b32.out_ready) begin
      if (q32.size() == 0) begin
        total++;
        bad++;
        $display("[TB] FAIL out32_unexpected actual=imm %h required=no output",
                 b32.imm_out);
      end else begin
        e32 = q32.pop_front();
        check_output("out32_imm", {32'b0, b32.imm_out}, e32.imm);
        check_output("out32_target", {32'b0, b32.target_out}, e32.target);
        check_output("out32_illegal", {63'b0, b32.illegal_imm}, {63'b0, e32.ill});
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && b64.out_valid && b64.out_ready) begin
      if (q64.size() == 0) begin
        total++;
        bad++;
        $display("[TB] FAIL out64_unexpected actual=imm %h required=no output",
                 b64.imm_out);
      end else begin
        e64 = q64.pop_front();
        check_output("out64_imm", b64.imm_out, e64.imm);
        check_output("out64_target", b64.target_out, e64.target);
        check_output("out64_illegal", {63'b0, b64.illegal_imm}, {63'b0, e64.ill});
      end
    end
  end

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    b32.in_valid = 1'b0; b32.instr_in = '0; b32.imm_sel_in = '0;
    b32.pc_in = '0; b32.flush = 1'b0; b32.out_ready = 1'b1;
    b64.in_valid = 1'b0; b64.instr_in = '0; b64.imm_sel_in = '0;
    b64.pc_in = '0; b64.flush = 1'b0; b64.out_ready = 1'b1;

    // Reset state
    #12;
    check_output("rst32_out_valid", {63'b0, b32.out_valid}, 64'd0);
    check_output("rst32_imm", {32'b0, b32.imm_out}, 64'd0);
    check_output("rst32_target", {32'b0, b32.target_out}, 64'd0);
    check_output("rst32_illegal", {63'b0, b32.illegal_imm}, 64'd0);
    check_output("rst32_in_ready", {63'b0, b32.in_ready}, 64'd1);
    check_output("rst64_out_valid", {63'b0, b64.out_valid}, 64'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // 32-bit formats, back to back
    send32(32'hFFF00093, 3'b000, 32'h0,        32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
    send32(32'hFE000EE3, 3'b010, 32'h100,      32'hFFFFFFFC, 32'h000000FC, 1'b0);
    send32(32'hFE112C23, 3'b001, 32'h8,        32'hFFFFFFF8, 32'h00000000, 1'b0);
    send32(32'hFFDFF06F, 3'b100, 32'h1000,     32'hFFFFFFFC, 32'h00000FFC, 1'b0);
    send32(32'h800000B7, 3'b011, 32'h10,       32'h80000000, 32'h80000010, 1'b0);
    send32(32'h000A8073, 3'b101, 32'h40,       32'h00000015, 32'h00000055, 1'b0);
    send32(32'h00000000, 3'b111, 32'h200,      32'h00000000, 32'h00000200, 1'b1);
    send32(32'h03F00013, 3'b110, 32'h0,        32'h0000001F, 32'h0000001F, 1'b1);
    send32(32'h02000093, 3'b000, 32'hFFFFFFF0, 32'h00000020, 32'h00000010, 1'b0);
    apply_stimulus_idle(3);

    // 64-bit formats on the non-skid instance
    send64(32'h800000B7, 3'b011, 64'h1000, 64'hFFFFFFFF80000000,
           64'hFFFFFFFF80001000, 1'b0);
    send64(32'h000F8073, 3'b101, 64'h0, 64'h1F, 64'h1F, 1'b0);
    send64(32'h03F00013, 3'b110, 64'h10, 64'h3F, 64'h4F, 1'b0);
    send64(32'hFFF00093, 3'b000, 64'h0, 64'hFFFFFFFFFFFFFFFF,
           64'hFFFFFFFFFFFFFFFF, 1'b0);
    send64(32'h00100093, 3'b000, 64'hFFFFFFFFFFFFFFFF, 64'h1, 64'h0, 1'b0);
    send64(32'hFE000EE3, 3'b010, 64'h100, 64'hFFFFFFFFFFFFFFFC, 64'hFC, 1'b0);
    send64(32'h00000000, 3'b111, 64'h300, 64'h0, 64'h300, 1'b1);
    apply_stimulus_idle(3);

    // Skid backpressure: A to main, B to skid, C held upstream
    send32(32'h00100013, 3'b000, 32'h0, 32'h1, 32'h1, 1'b0);
    b32.out_ready = 1'b0;
    send32(32'h00200013, 3'b000, 32'h0, 32'h2, 32'h2, 1'b0);
    b32.instr_in = 25'(32'h00300013 >> 7);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_output("bp32_in_ready", {63'b0, b32.in_ready}, 64'd0);
      check_output("bp32_out_valid", {63'b0, b32.out_valid}, 64'd1);
      check_output("bp32_hold_imm", {32'b0, b32.imm_out}, 64'd1);
    end
    @(posedge clk);
    #1;
    b32.out_ready = 1'b1;
    send32(32'h00300013, 3'b000, 32'h0, 32'h3, 32'h3, 1'b0);
    apply_stimulus_idle(3);
    check_output("bp32_drained", 64'(q32.size()), 64'd0);

    // Flush with main and skid full and an input offered in the same cycle
    b32.out_ready = 1'b0;
    send32(32'h00400013, 3'b000, 32'h0, 32'h4, 32'h4, 1'b0);
    send32(32'h00500013, 3'b000, 32'h0, 32'h5, 32'h5, 1'b0);
    b32.in_valid = 1'b1;
    b32.instr_in = 25'(32'h00600013 >> 7);
    b32.flush    = 1'b1;
    q32.delete();
    @(posedge clk);
    #1;
    b32.flush    = 1'b0;
    b32.in_valid = 1'b0;
    @(negedge clk);
    check_output("flush32_out_valid", {63'b0, b32.out_valid}, 64'd0);
    check_output("flush32_in_ready", {63'b0, b32.in_ready}, 64'd1);
    b32.out_ready = 1'b1;
    apply_stimulus_idle(4);

    // Non-skid backpressure: in_ready follows out_ready while held
    b64.out_ready = 1'b0;
    send64(32'h00700013, 3'b000, 64'h0, 64'h7, 64'h7, 1'b0);
    b64.instr_in = 25'(32'h00800013 >> 7);
    @(negedge clk);
    check_output("bp64_in_ready", {63'b0, b64.in_ready}, 64'd0);
    check_output("bp64_hold_imm", b64.imm_out, 64'h7);
    @(posedge clk);
    #1;
    b64.out_ready = 1'b1;
    send64(32'h00800013, 3'b000, 64'h0, 64'h8, 64'h8, 1'b0);
    apply_stimulus_idle(2);

    // Non-skid flush: once with a held entry, once with an idle stage
    b64.out_ready = 1'b0;
    send64(32'h00900013, 3'b000, 64'h0, 64'h9, 64'h9, 1'b0);
    b64.in_valid = 1'b1;
    b64.flush    = 1'b1;
    q64.delete();
    @(posedge clk);
    #1;
    b64.flush = 1'b0;
    @(negedge clk);
    check_output("flush64_held_out_valid", {63'b0, b64.out_valid}, 64'd0);
    b64.in_valid  = 1'b0;
    b64.out_ready = 1'b1;
    @(posedge clk);
    #1;
    b64.in_valid = 1'b1;
    b64.instr_in = 25'(32'h00A00013 >> 7);
    b64.flush    = 1'b1;
    @(posedge clk);
    #1;
    b64.flush    = 1'b0;
    b64.in_valid = 1'b0;
    @(negedge clk);
    check_output("flush64_idle_out_valid", {63'b0, b64.out_valid}, 64'd0);
    apply_stimulus_idle(2);

    // Asynchronous reset mid-stream, then one-cycle latency on restart
    b32.out_ready = 1'b0;
    send32(32'hFFF00093, 3'b000, 32'h20, 32'hFFFFFFFF, 32'h0000001F, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check_output("arst_out_valid", {63'b0, b32.out_valid}, 64'd0);
    check_output("arst_imm", {32'b0, b32.imm_out}, 64'd0);
    check_output("arst_target", {32'b0, b32.target_out}, 64'd0);
    check_output("arst_in_ready", {63'b0, b32.in_ready}, 64'd1);
    q32.delete();
    q64.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    b32.out_ready = 1'b1;
    send32(32'h00B00013, 3'b000, 32'h4, 32'hB, 32'hF, 1'b0);
    b32.in_valid = 1'b0;
    @(negedge clk);
    check_output("arst_restart_valid", {63'b0, b32.out_valid}, 64'd1);

    apply_stimulus_idle(5);
    check_output("final32_drained", 64'(q32.size()), 64'd0);
    check_output("final64_drained", 64'(q64.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
